// File: rtl/vector_result_serializer.sv
// Snapshots an ALU result vector on capture and streams it out
// as a length header followed by one element per valid/ready beat.
module vector_result_serializer #(
  parameter int BITS = 8,
  parameter int N    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0][BITS-1:0]   S,
  input  logic [7:0]               S_len,
  input  logic                     capture,
  output logic                     busy,
  output logic                     drop,
  output logic [BITS-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA
  } state_t;

  state_t                 state;
  logic [N-1:0][BITS-1:0] snap;
  logic [7:0]             len_eff;
  logic [IW-1:0]          idx;

  logic [7:0]             cap_len;
  logic [IW-1:0]          idx_nxt;
  logic                   nxt_last;

  // The header keeps the raw S_len; only the data beats are clamped to N.
  assign cap_len  = (S_len > 8'(N)) ? 8'(N) : S_len;
  assign idx_nxt  = idx + IW'(1);
  assign nxt_last = (8'(idx_nxt) == (len_eff - 8'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      snap      <= '0;
      len_eff   <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      drop      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      drop <= capture && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (capture) begin
            state     <= HEADER;
            snap      <= S;
            len_eff   <= cap_len;
            idx       <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= BITS'(S_len);
            out_last  <= (cap_len == 8'd0);
          end
        end
        HEADER: begin
          if (out_ready) begin
            if (len_eff == 8'd0) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              state    <= DATA;
              idx      <= '0;
              out_data <= snap[0];
              out_last <= (len_eff == 8'd1);
            end
          end
        end
        DATA: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              idx      <= idx_nxt;
              out_data <= snap[idx_nxt];
              out_last <= nxt_last;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_result_serializer.sv
// Directed bench for vector_result_serializer: cycle table for
// plain frames plus scripted backpressure, overlap and reset runs.
module tb_vector_result_serializer;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0][7:0] s;
  logic [7:0]      s_len;
  logic            capture;
  logic            busy;
  logic            drop;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_result_serializer #(.BITS(8), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .S         (s),
    .S_len     (s_len),
    .capture   (capture),
    .busy      (busy),
    .drop      (drop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  typedef struct {
    logic            rst_n;
    logic            cap;
    logic            rdy;
    logic [3:0][7:0] s;
    logic [7:0]      len;
    logic            v;
    logic [7:0]      d;
    logic            l;
    logic            b;
    logic            dr;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [7:0] d,
                         input logic l, input logic b, input logic dr);
    chk({nm, ".valid"}, 32'(out_valid), 32'(v));
    if (v) chk({nm, ".data"}, 32'(out_data), 32'(d));
    chk({nm, ".last"}, 32'(out_last), 32'(l));
    chk({nm, ".busy"}, 32'(busy), 32'(b));
    chk({nm, ".drop"}, 32'(drop), 32'(dr));
  endtask

  logic [3:0][7:0] sa, sb, sc;
  logic [7:0] exp_q[5];
  logic [7:0] prev_d;
  logic       prev_stall;
  int         pos;
  int         cyc;
  logic       rdy_pat[12];

  initial begin
    sa = {8'd20, 8'd10, 8'd5, 8'd0};
    sb = {8'd4, 8'd3, 8'd2, 8'd1};

    tbl[0]  = '{1'b0, 1'b0, 1'b1, sa, 8'd4, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, sa, 8'd4, 1'b1, 8'd4,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, sa, 8'd4, 1'b1, 8'd0,  1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, sa, 8'd4, 1'b1, 8'd5,  1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, sa, 8'd4, 1'b1, 8'd10, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, sa, 8'd4, 1'b1, 8'd20, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, sa, 8'd4, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, sa, 8'd0, 1'b1, 8'd0,  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, sa, 8'd0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, sb, 8'd9, 1'b1, 8'd9,  1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, sb, 8'd9, 1'b1, 8'd1,  1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, sb, 8'd9, 1'b1, 8'd2,  1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, sb, 8'd9, 1'b1, 8'd3,  1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, sb, 8'd9, 1'b1, 8'd4,  1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, sb, 8'd9, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    capture = 1'b0;
    out_ready = 1'b1;
    s = '0;
    s_len = '0;
    #1;

    for (int i = 0; i < 15; i++) begin
      rst_n     = tbl[i].rst_n;
      capture   = tbl[i].cap;
      out_ready = tbl[i].rdy;
      s         = tbl[i].s;
      s_len     = tbl[i].len;
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].v, tbl[i].d, tbl[i].l,
              tbl[i].b, tbl[i].dr);
    end
    capture = 1'b0;

    // Backpressure with S/S_len overwritten right after capture.
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_q = '{8'd4, 8'd7, 8'd8, 8'd9, 8'd10};
    s = {8'd10, 8'd9, 8'd8, 8'd7};
    s_len = 8'd4;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    s = {4{8'hFF}};
    s_len = 8'hFF;
    pos = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    while (pos < 5 && cyc < 40) begin
      out_ready = rdy_pat[cyc % 12];
      chk($sformatf("bp.valid%0d", cyc), 32'(out_valid), 32'd1);
      if (prev_stall)
        chk($sformatf("bp.hold%0d", cyc), 32'(out_data), 32'(prev_d));
      chk($sformatf("bp.data%0d", pos), 32'(out_data), 32'(exp_q[pos]));
      chk($sformatf("bp.last%0d", cyc), 32'(out_last), 32'(pos == 4));
      prev_stall = !out_ready;
      prev_d = out_data;
      if (out_ready) pos++;
      cyc++;
      tick();
    end
    if (pos < 5) begin
      errors++;
      $display("FAIL bp.timeout: got %0d beats required 5", pos);
    end
    out_ready = 1'b1;
    chk("bp.idle_valid", 32'(out_valid), 32'd0);
    chk("bp.idle_busy", 32'(busy), 32'd0);

    // Overlapping captures: mid-frame and on the final-beat transfer.
    s = sb;
    s_len = 8'd4;
    capture = 1'b1;
    tick();
    chk_out("ov.hdr", 1'b1, 8'd4, 1'b0, 1'b1, 1'b0);
    s = {4{8'hAA}};
    s_len = 8'd2;
    tick();
    chk_out("ov.d1", 1'b1, 8'd1, 1'b0, 1'b1, 1'b1);
    capture = 1'b0;
    tick();
    chk_out("ov.d2", 1'b1, 8'd2, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("ov.d3", 1'b1, 8'd3, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("ov.d4", 1'b1, 8'd4, 1'b1, 1'b1, 1'b0);
    capture = 1'b1;
    tick();
    chk_out("ov.end", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    capture = 1'b0;
    tick();
    chk_out("ov.after", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Reset during DATA with idx=2, then a full frame.
    sc = {8'd44, 8'd33, 8'd22, 8'd11};
    s = sc;
    s_len = 8'd4;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    chk_out("rs.hdr", 1'b1, 8'd4, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk_out("rs.idx2", 1'b1, 8'd33, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_out("rs.rst", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("rs.data0", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_out("rs.quiet", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    chk_out("rs.f_hdr", 1'b1, 8'd4, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("rs.f_d%0d", k), 1'b1, sc[k], 1'(k == 3),
              1'b1, 1'b0);
    end
    tick();
    chk_out("rs.f_idle", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
